// File: rtl/sr_ff_pkg.sv
// Shared types and constants for the s/r flip-flop exerciser.
// The vector encoding is {s,r}; the exerciser walks VEC_FIRST..VEC_LAST each round.
package sr_ff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [1:0] vec_t;

    localparam vec_t VEC_FIRST = 2'b00;
    localparam vec_t VEC_LAST  = 2'b11;

    // The DUT must echo the stimulus: q follows s, qi follows r.
    function automatic logic vec_mismatch(input vec_t vec, input logic q, input logic qi);
        return (q != vec[1]) || (qi != vec[0]);
    endfunction

endpackage

// File: rtl/sr_ff_exerciser_vecgen.sv
// Vector index and round counter for the exerciser.
// vec_o is a register output, so s/r driven from it are glitch-free.
module sr_vector_gen
    import sr_ff_pkg::*;
#(
    parameter int ROUNDS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic advance_i,
    output vec_t vec_o,
    output logic last_o
);

    vec_t       idx_q, idx_d;
    logic [7:0] round_q, round_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= VEC_FIRST;
            round_q <= 8'd0;
        end else begin
            idx_q   <= idx_d;
            round_q <= round_d;
        end
    end

    // Advancing past the last vector of the last round wraps to 00, which
    // leaves s=r=0 for DONE/IDLE.
    always_comb begin
        idx_d   = idx_q;
        round_d = round_q;
        if (clear_i) begin
            idx_d   = VEC_FIRST;
            round_d = 8'd0;
        end else if (advance_i) begin
            if (idx_q == VEC_LAST) begin
                idx_d   = VEC_FIRST;
                round_d = round_q + 8'd1;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    assign vec_o  = idx_q;
    assign last_o = (idx_q == VEC_LAST) && (round_q == 8'(ROUNDS - 1));

endmodule

// File: rtl/sr_ff_exerciser.sv
// Stimulus/check engine for an s/r flip-flop pair: drives every {s,r} vector
// for ROUNDS passes, compares q/qi LATENCY+1 cycles after each change.
module sr_ff_exerciser
    import sr_ff_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int ROUNDS  = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             s_o,
    output logic             r_o,
    input  logic             q_i,
    input  logic             qi_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [1:0]       first_err_vec_o,
    output logic [1:0]       state_o
);

    localparam logic [3:0]       LAT_END = 4'(LATENCY - 1);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    state_e           state_q, state_d;
    logic [3:0]       lat_q, lat_d;
    logic [CNT_W-1:0] err_q, err_d;
    vec_t             first_q, first_d;
    logic             pass_q, pass_d;

    vec_t vec;
    logic last;
    logic clear;
    logic advance;
    logic mismatch;

    assign clear    = (state_q == ST_IDLE) && start_i;
    assign advance  = (state_q == ST_CHECK);
    assign mismatch = vec_mismatch(vec, q_i, qi_i);

    sr_vector_gen #(
        .ROUNDS(ROUNDS)
    ) u_vecgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .advance_i(advance),
        .vec_o    (vec),
        .last_o   (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lat_q   <= 4'd0;
            err_q   <= '0;
            first_q <= VEC_FIRST;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    // WAIT spans LATENCY cycles and CHECK one more, so each vector is held
    // LATENCY+1 cycles and the compare lands on the edge leaving CHECK.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_WAIT;
            ST_WAIT:  if (lat_q == LAT_END) state_d = ST_CHECK;
            ST_CHECK: state_d = last ? ST_DONE : ST_WAIT;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lat_d   = (state_q == ST_WAIT) ? lat_q + 4'd1 : 4'd0;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        if (clear) begin
            err_d   = '0;
            first_d = VEC_FIRST;
            pass_d  = 1'b0;
        end else if (state_q == ST_CHECK) begin
            if (mismatch) begin
                if (err_q == '0) first_d = vec;
                if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            end
            if (last) pass_d = (err_d == '0);
        end
    end

    always_comb begin
        busy_o = (state_q == ST_WAIT) || (state_q == ST_CHECK);
        done_o = (state_q == ST_DONE);
    end

    assign s_o             = vec[1];
    assign r_o             = vec[0];
    assign pass_o          = pass_q;
    assign err_count_o     = err_q;
    assign first_err_vec_o = first_q;
    assign state_o         = state_q;

endmodule
